// File: rtl/datapath_sequencer.sv
// datapath_sequencer: instruction sequencer driving regfile/A/B/C/bus-mux/ALU controls with ABus write-back.
// Optional SEQ_R0_ZERO_EN makes register 0 read-only zero by suppressing its write-back.
module datapath_sequencer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int RD_WAIT  = 1,
  parameter int EXEC_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3+3*ADDR_W-1:0] instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic                  abort_i,
  input  logic [DATA_W-1:0]     abus_i,
  output logic [ADDR_W-1:0]     ReadAddr1_o,
  output logic [ADDR_W-1:0]     ReadAddr2_o,
  output logic                  LD_A_o,
  output logic                  LD_B_o,
  output logic                  LD_C_o,
  output logic                  OEA_o,
  output logic                  OEB_o,
  output logic                  OEC_o,
  output logic [1:0]            SelMux_o,
  output logic [2:0]            opcode_o,
  output logic                  enableALU_o,
  output logic                  WriteEnable_o,
  output logic [ADDR_W-1:0]     WriteAddr_o,
  output logic [DATA_W-1:0]     WriteData_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            instr_cnt_o
);
  typedef enum logic [2:0] {IDLE, RD, LDAB, EXEC, WB, WR} state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [2:0] op;
  logic [ADDR_W-1:0] dst, src1, src2;
  logic [DATA_W-1:0] wdata;
  logic [7:0] icnt;
  logic kill, wb_ok;
  assign kill  = abort_i && (state == RD || state == LDAB || state == EXEC || state == WB);
  assign wb_ok = state == WB && !abort_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      {op, dst, src1, src2} <= '0;
      wdata <= '0;
      icnt  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && instr_valid_i) begin
        {op, dst, src1, src2} <= instr_i;
        cnt <= 4'(RD_WAIT - 1);
      end else if (state == LDAB)
        cnt <= 4'(EXEC_CYC - 1);
      else if ((state == RD || state == EXEC) && cnt != 0)
        cnt <= cnt - 4'd1;
      // counter steps on entering WR so the new value is visible with done_o
      if (wb_ok) begin
        wdata <= abus_i;
        icnt  <= icnt + 8'd1;
      end
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = instr_valid_i ? RD : IDLE;
      RD:      next = cnt == 0 ? LDAB : RD;
      LDAB:    next = EXEC;
      EXEC:    next = cnt == 0 ? WB : EXEC;
      WB:      next = WR;
      WR:      next = IDLE;
      default: next = IDLE;
    endcase
    if (kill) next = IDLE;
  end
  always_comb begin
    instr_ready_o = state == IDLE;
    busy_o        = state != IDLE;
    ReadAddr1_o   = state != IDLE ? src1 : '0;
    ReadAddr2_o   = state != IDLE ? src2 : '0;
    LD_A_o        = state == LDAB;
    LD_B_o        = state == LDAB;
    OEA_o         = state == EXEC;
    OEB_o         = state == EXEC;
    enableALU_o   = state == EXEC;
    opcode_o      = state == EXEC ? op : 3'b000;
    LD_C_o        = state == EXEC && cnt == 0;
    OEC_o         = state == WB;
    SelMux_o      = state == EXEC ? 2'b11 : state == WB ? 2'b10 : 2'b00;
`ifdef SEQ_R0_ZERO_EN
    WriteEnable_o = state == WR && dst != '0;
`else
    WriteEnable_o = state == WR;
`endif
    WriteAddr_o   = state == WR ? dst : '0;
    WriteData_o   = state == WR ? wdata : '0;
    done_o        = state == WR;
  end
  assign instr_cnt_o = icnt;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed bench with a write-back scoreboard for datapath_sequencer.
module tb_datapath_sequencer;
  localparam bit R0Z =
`ifdef SEQ_R0_ZERO_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic [17:0] instr = '0, instr2 = '0;
  logic valid = 0, valid2 = 0, abort = 0;
  logic [7:0] abus = '0;
  logic ready, ld_a, ld_b, ld_c, oea, oeb, oec, ena, we, busy, done;
  logic [4:0] ra1, ra2, waddr;
  logic [1:0] sel;
  logic [2:0] opc;
  logic [7:0] wd, icnt;
  logic ready2, ld_a2, ld_b2, ld_c2, oea2, oeb2, oec2, ena2, we2, busy2, done2;
  logic [4:0] ra1_2, ra2_2, waddr2;
  logic [1:0] sel2;
  logic [2:0] opc2;
  logic [7:0] wd2, icnt2;
  datapath_sequencer dut (
    .clk(clk), .rst(rst), .instr_i(instr), .instr_valid_i(valid), .instr_ready_o(ready),
    .abort_i(abort), .abus_i(abus), .ReadAddr1_o(ra1), .ReadAddr2_o(ra2),
    .LD_A_o(ld_a), .LD_B_o(ld_b), .LD_C_o(ld_c), .OEA_o(oea), .OEB_o(oeb), .OEC_o(oec),
    .SelMux_o(sel), .opcode_o(opc), .enableALU_o(ena), .WriteEnable_o(we),
    .WriteAddr_o(waddr), .WriteData_o(wd), .busy_o(busy), .done_o(done), .instr_cnt_o(icnt));
  datapath_sequencer #(.RD_WAIT(3), .EXEC_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .instr_i(instr2), .instr_valid_i(valid2), .instr_ready_o(ready2),
    .abort_i(1'b0), .abus_i(abus), .ReadAddr1_o(ra1_2), .ReadAddr2_o(ra2_2),
    .LD_A_o(ld_a2), .LD_B_o(ld_b2), .LD_C_o(ld_c2), .OEA_o(oea2), .OEB_o(oeb2), .OEC_o(oec2),
    .SelMux_o(sel2), .opcode_o(opc2), .enableALU_o(ena2), .WriteEnable_o(we2),
    .WriteAddr_o(waddr2), .WriteData_o(wd2), .busy_o(busy2), .done_o(done2), .instr_cnt_o(icnt2));
  typedef struct {logic we; logic [4:0] addr; logic [7:0] data; logic [7:0] cnt;} wr_t;
  wr_t sb[$];
  int compared = 0, mismatched = 0;
  logic [7:0] exp_cnt = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [2:0] o, input logic [4:0] d, s1, s2, input logic [7:0] data, input bit push);
    instr = {o, d, s1, s2};
    abus  = data;
    valid = 1;
    if (push) begin
      exp_cnt++;
      sb.push_back('{R0Z ? (d != 0) : 1'b1, d, data, exp_cnt});
    end
  endtask
  task automatic check_wr();
    wr_t e;
    chk("done", done, 1);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("we", we, e.we);
      chk("waddr", waddr, e.addr);
      chk("wdata", wd, e.data);
      chk("cnt", icnt, e.cnt);
    end
  endtask
  task automatic finish_instr(input int lat);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, lat);
    check_wr();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [9:0] m_lda, m_ena, m_ldc, m_we, m_rd;
    int hits;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(negedge clk);
    chk("rst_strobes", {ld_a, ld_b, ld_c, oea, oeb, oec, ena, we, done, busy}, 0);
    chk("rst_sel", sel, 0);
    chk("rst_ready", ready, 1);
    chk("rst_cnt", icnt, 0);
    chk("rst_ready2", ready2, 1);
    // basic instruction at default timing
    drive(3'b010, 5'd7, 5'd1, 5'd2, 8'h5A, 1);
    chk("instr_enc", instr, 18'h11C22);
    @(negedge clk) valid = 0;
    chk("c1_ra", {ra1, ra2}, {5'd1, 5'd2});
    chk("c1_busy_ready", {busy, ready}, 2'b10);
    chk("c1_lda", ld_a, 0);
    @(negedge clk);
    chk("c2_ldab", {ld_a, ld_b, ena}, 3'b110);
    @(negedge clk);
    chk("c3_exec", {ena, oea, oeb, ld_c, opc, sel}, {4'b1111, 3'b010, 2'b11});
    @(negedge clk);
    chk("c4_wb", {oec, sel, we, ena}, {1'b1, 2'b10, 2'b00});
    @(negedge clk);
    check_wr();
    // abort in EXEC
    @(negedge clk);
    drive(3'b001, 5'd3, 5'd4, 5'd5, 8'hC3, 0);
    @(negedge clk) valid = 0;
    @(negedge clk);
    @(negedge clk) abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_idle", {busy, ready}, 2'b01);
    hits = 0;
    repeat (6) @(negedge clk) hits += int'(done | we);
    chk("abort_nowrite", hits, 0);
    chk("abort_cnt", icnt, exp_cnt);
    // abort in WR is ignored
    drive(3'b100, 5'd4, 5'd6, 5'd8, 8'h3C, 1);
    @(negedge clk) valid = 0;
    repeat (3) @(negedge clk);
    @(negedge clk) abort = 1;
    check_wr();
    @(negedge clk) abort = 0;
    chk("wr_abort_cnt", icnt, exp_cnt);
    chk("wr_abort_ready", ready, 1);
    // abort with valid in IDLE still accepts
    abort = 1;
    drive(3'b111, 5'd9, 5'd10, 5'd11, 8'h96, 1);
    @(negedge clk) begin abort = 0; valid = 0; end
    chk("idle_abort_accept", busy, 1);
    finish_instr(4);
    // write to register 0
    @(negedge clk);
    drive(3'b011, 5'd0, 5'd1, 5'd1, 8'hE7, 1);
    @(negedge clk) valid = 0;
    finish_instr(4);
    // 256 back-to-back with valid held high
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      drive(3'(i), 5'(i), 5'(i + 3), 5'(i * 7), 8'($urandom), 1);
      finish_instr(5);
      @(negedge clk);
      chk("b2b_ready", ready, 1);
    end
    valid = 0;
    chk("b2b_cnt", icnt, exp_cnt);
    // RD_WAIT=3, EXEC_CYC=2 instance
    instr2 = {3'b101, 5'd2, 5'd3, 5'd4};
    valid2 = 1;
    {m_lda, m_ena, m_ldc, m_we, m_rd} = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk) valid2 = 0;
      m_lda[c] = ld_a2;
      m_ena[c] = ena2;
      m_ldc[c] = ld_c2;
      m_we[c]  = we2;
      m_rd[c]  = busy2 && ra1_2 == 5'd3 && !ld_a2 && !ena2 && !oec2 && !we2;
    end
    chk("p_rd", m_rd, 10'b0000001110);
    chk("p_lda", m_lda, 10'b0000010000);
    chk("p_ena", m_ena, 10'b0001100000);
    chk("p_ldc", m_ldc, 10'b0001000000);
    chk("p_we", m_we, 10'b0100000000);
    chk("p_cnt", icnt2, 1);
    // reset mid-instruction
    drive(3'b110, 5'd5, 5'd6, 5'd7, 8'h11, 0);
    @(negedge clk) valid = 0;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst", {busy, ena, oea, ld_c, ready}, 5'b00001);
    chk("mid_rst_cnt", icnt, 0);
    @(negedge clk) rst = 1;
    hits = 0;
    repeat (8) @(negedge clk) hits += int'(done | we);
    chk("mid_rst_nowrite", hits, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
